ct_ifu_spsram_128x16_ctrl: RTL and testbench

- Access controller that sits directly upstream of the 128x16 single-port IFU SRAM wrapper and drives its A/CEN/GWEN/WEN/D pins.
- Arbitrates one read client against one masked-write client, using a one-entry write buffer with anti-starvation.
- Clears the array after reset or on invalidate.
- Returns read data with fixed 1-cycle latency, merging any pending buffered write into the result.

---
 rtl/ct_ifu_spsram_128x16_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ct_ifu_spsram_128x16_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ct_ifu_spsram_128x16_ctrl.sv
// ct_ifu_spsram_128x16_ctrl: access controller driving the A/CEN/GWEN/WEN/D
// pins of the 128x16 IFU SRAM wrapper. One read client and one masked-write
// client share the single port; a one-entry write buffer holds a write that
// loses to a read, with a starvation counter forcing it out. The array is
// swept to INIT_VAL after reset or inv_req. Read data returns 1 cycle after
// rd_gnt.
// Ports: forever_cpuclk/cpurst (sync, active-high); inv_req, init_done;
//   rd_req/rd_idx/rd_gnt/rd_vld/rd_data; wr_req/wr_idx/wr_data/wr_mask/wr_gnt;
//   sram_a/sram_cen/sram_gwen/sram_wen/sram_d out, sram_q in.
// Option: define CT_SPSRAM_RAW_BYPASS_EN to let a read hit the pending
//   buffered write and merge it into rd_data instead of waiting for the drain.
module ct_ifu_spsram_128x16_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = 16'h0000,
  parameter int STARVE_MAX = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  inv_req,
  output logic                  init_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  buf_vld_q, buf_vld_d;
  logic [ADDR_WIDTH-1:0] buf_idx_q, buf_idx_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [DATA_WIDTH-1:0] buf_mask_q, buf_mask_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rst_q;

  // rst_q holds everything quiet for the first cycle after cpurst falls
  logic blk, idle, sweep, hit, starved;
  logic rd_go, drain, wr_live, wr_buf, wr_dir;

  assign blk     = cpurst | rst_q;
  assign idle    = (state_q == ST_IDLE) & ~blk & ~inv_req;
  assign sweep   = (state_q == ST_INIT) & ~blk & ~inv_req;
  assign hit     = buf_vld_q & (rd_idx == buf_idx_q);
  assign starved = buf_vld_q & (starve_q == SMAX);

`ifdef CT_SPSRAM_RAW_BYPASS_EN
  assign rd_go = idle & rd_req & ~starved;
`else
  // a read of the buffered index waits; the drain goes first
  assign rd_go = idle & rd_req & ~starved & ~hit;
`endif

  assign drain     = idle & buf_vld_q & ~rd_go;
  assign init_done = (state_q == ST_IDLE) & ~blk;
  assign wr_gnt    = init_done & ~buf_vld_q & ~inv_req;
  assign rd_gnt    = rd_go;
  assign wr_live   = wr_req & wr_gnt & (|wr_mask);
  assign wr_buf    = wr_live & rd_go;
  assign wr_dir    = wr_live & ~rd_go;
  assign rd_vld    = rd_vld_q;

`ifdef CT_SPSRAM_RAW_BYPASS_EN
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic [DATA_WIDTH-1:0] byp_mask_q, byp_mask_d;

  always_comb begin
    byp_data_d = buf_data_q;
    byp_mask_d = (rd_go & hit) ? buf_mask_q : '0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else begin
      byp_data_q <= byp_data_d;
      byp_mask_q <= byp_mask_d;
    end
  end

  assign rd_data = rd_vld_q
    ? ((sram_q & ~byp_mask_q) | (byp_data_q & byp_mask_q))
    : '0;
`else
  assign rd_data = rd_vld_q ? sram_q : '0;
`endif

  // state register
  always_ff @(posedge forever_cpuclk) begin
    rst_q <= cpurst;
    if (cpurst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_data_q <= '0;
      buf_mask_q <= '0;
      starve_q   <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      buf_vld_q  <= buf_vld_d;
      buf_idx_q  <= buf_idx_d;
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      starve_q   <= starve_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // next state
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    buf_vld_d  = buf_vld_q;
    buf_idx_d  = buf_idx_q;
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    starve_d   = starve_q;
    rd_vld_d   = rd_go;
    if (inv_req) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      buf_vld_d  = 1'b0;
      starve_d   = '0;
    end else if (sweep) begin
      init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
      if (&init_cnt_q) state_d = ST_IDLE;
    end else if (idle) begin
      if (drain) begin
        buf_vld_d = 1'b0;
        starve_d  = '0;
      end else if (buf_vld_q && starve_q != SMAX) begin
        starve_d = starve_q + SW'(1);
      end
      if (wr_buf) begin
        buf_vld_d  = 1'b1;
        buf_idx_d  = wr_idx;
        buf_data_d = wr_data;
        buf_mask_d = wr_mask;
        starve_d   = '0;
      end
    end
  end

  // SRAM pin drive, one access per cycle
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    unique case (1'b1)
      sweep: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt_q;
        sram_d    = INIT_VAL;
      end
      rd_go: begin
        sram_cen = 1'b0;
        sram_a   = rd_idx;
      end
      drain: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = ~buf_mask_q;
        sram_a    = buf_idx_q;
        sram_d    = buf_data_q;
      end
      wr_dir: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = ~wr_mask;
        sram_a    = wr_idx;
        sram_d    = wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ct_ifu_spsram_128x16_ctrl.sv
// tb_ct_ifu_spsram_128x16_ctrl: directed bench for the IFU SRAM controller
// with a behavioural 128x16 single-port array on the SRAM pins.
module tb_ct_ifu_spsram_128x16_ctrl;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        inv_req;
  logic        init_done;
  logic        rd_req;
  logic [6:0]  rd_idx;
  logic        rd_gnt;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [6:0]  wr_idx;
  logic [15:0] wr_data;
  logic [15:0] wr_mask;
  logic        wr_gnt;
  logic [6:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [15:0] sram_wen;
  logic [15:0] sram_d;
  logic [15:0] sram_q;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mem [128];

  always #5 clk = ~clk;

  ct_ifu_spsram_128x16_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst(cpurst),
    .inv_req(inv_req),
    .init_done(init_done),
    .rd_req(rd_req),
    .rd_idx(rd_idx),
    .rd_gnt(rd_gnt),
    .rd_vld(rd_vld),
    .rd_data(rd_data),
    .wr_req(wr_req),
    .wr_idx(wr_idx),
    .wr_data(wr_data),
    .wr_mask(wr_mask),
    .wr_gnt(wr_gnt),
    .sram_a(sram_a),
    .sram_cen(sram_cen),
    .sram_gwen(sram_gwen),
    .sram_wen(sram_wen),
    .sram_d(sram_d),
    .sram_q(sram_q)
  );

  initial begin
    sram_q = 16'h0;
    for (int i = 0; i < 128; i++) mem[i] = 16'hDEAD;
  end

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        mem[sram_a] <= (mem[sram_a] & sram_wen)
                     | (sram_d & ~sram_wen);
      else
        sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [6:0] ri,
                     input logic w, input logic [6:0] wi,
                     input logic [15:0] wd, input logic [15:0] wm,
                     input logic iv);
    @(negedge clk);
    rd_req  = r;
    rd_idx  = ri;
    wr_req  = w;
    wr_idx  = wi;
    wr_data = wd;
    wr_mask = wm;
    inv_req = iv;
    #1;
  endtask

  // 128 write cycles with both clients requesting, then the first IDLE cycle
  task automatic sweep_chk(input string tag);
    for (int i = 0; i < 128; i++) begin
      cyc(1, 7'd0, 1, 7'd1, 16'h1111, 16'hFFFF, 0);
      chk(tag,
          {sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
           rd_gnt, wr_gnt, init_done},
          {1'b0, 1'b0, 16'h0000, 7'(i), 16'h0000, 3'b000});
    end
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk({tag, "_done"}, {init_done, sram_cen}, {1'b1, 1'b1});
  endtask

  initial begin
    cpurst  = 1'b1;
    inv_req = 1'b0;
    rd_req  = 1'b0;
    rd_idx  = '0;
    wr_req  = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    wr_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst",
        {init_done, rd_gnt, wr_gnt, rd_vld, rd_data,
         sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
        {4'b0000, 16'h0, 1'b1, 1'b1, 16'hFFFF, 7'd0, 16'h0});
    cpurst = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    wr_mask = 16'hFFFF;
    #1;
    chk("rst_rel",
        {init_done, rd_gnt, wr_gnt, sram_cen, sram_gwen},
        {3'b000, 1'b1, 1'b1});

    sweep_chk("sweep");

    // direct write then read back
    cyc(0, 7'd0, 1, 7'd5, 16'hA5A5, 16'hFFFF, 0);
    chk("wr5",
        {wr_gnt, sram_cen, sram_gwen, sram_a, sram_wen, sram_d},
        {1'b1, 1'b0, 1'b0, 7'd5, 16'h0000, 16'hA5A5});
    cyc(1, 7'd5, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd5_gnt", {rd_gnt, sram_cen, sram_gwen, sram_a},
        {1'b1, 1'b0, 1'b1, 7'd5});
    cyc(1, 7'd6, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd5_data", {rd_vld, rd_data}, {1'b1, 16'hA5A5});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd6_data", {rd_vld, rd_data}, {1'b1, 16'h0000});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd_idle", {rd_vld, rd_data}, {1'b0, 16'h0000});

    // read and write together: write buffered, drained next idle cycle
    cyc(1, 7'd3, 1, 7'd9, 16'h1234, 16'hFFFF, 0);
    chk("rw_same", {rd_gnt, wr_gnt, sram_cen, sram_gwen, sram_a},
        {1'b1, 1'b1, 1'b0, 1'b1, 7'd3});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("buf_gnt", wr_gnt, 0);
    chk("buf_drain",
        {sram_cen, sram_gwen, sram_a, sram_wen, sram_d},
        {1'b0, 1'b0, 7'd9, 16'h0000, 16'h1234});
    chk("rd3_data", {rd_vld, rd_data}, {1'b1, 16'h0000});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("buf_free", {wr_gnt, sram_cen}, {1'b1, 1'b1});
    cyc(1, 7'd9, 0, 7'd0, 16'h0, 16'h0, 0);
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd9_data", {rd_vld, rd_data}, {1'b1, 16'h1234});

    // starvation: buffered write forced out after 4 blocked cycles
    cyc(1, 7'd0, 1, 7'd20, 16'hBEEF, 16'hFFFF, 0);
    chk("stv_cap", {rd_gnt, wr_gnt}, {1'b1, 1'b1});
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
      chk("stv_rd", {rd_gnt, wr_gnt, sram_cen, sram_gwen},
          {1'b1, 1'b0, 1'b0, 1'b1});
    end
    cyc(1, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("stv_drain", {rd_gnt, sram_cen, sram_gwen, sram_a, sram_d},
        {1'b0, 1'b0, 1'b0, 7'd20, 16'hBEEF});
    cyc(1, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("stv_resume", {rd_gnt, wr_gnt}, {1'b1, 1'b1});
    cyc(1, 7'd20, 0, 7'd0, 16'h0, 16'h0, 0);
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd20_data", {rd_vld, rd_data}, {1'b1, 16'hBEEF});

    // partial-mask buffered write hit by a read
    cyc(0, 7'd0, 1, 7'd7, 16'h00FF, 16'hFFFF, 0);
    chk("wr7", {wr_gnt, sram_a, sram_gwen}, {1'b1, 7'd7, 1'b0});
    cyc(1, 7'd0, 1, 7'd7, 16'hFF00, 16'h0F00, 0);
    chk("raw_cap", {rd_gnt, wr_gnt}, {1'b1, 1'b1});
    cyc(1, 7'd7, 0, 7'd0, 16'h0, 16'h0, 0);
`ifdef CT_SPSRAM_RAW_BYPASS_EN
    chk("raw_gnt", {rd_gnt, sram_gwen, sram_a}, {1'b1, 1'b1, 7'd7});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("raw_data", {rd_vld, rd_data}, {1'b1, 16'h0FFF});
    chk("raw_drain", {sram_cen, sram_gwen, sram_a, sram_wen, sram_d},
        {1'b0, 1'b0, 7'd7, 16'hF0FF, 16'hFF00});
`else
    chk("raw_blk",
        {rd_gnt, sram_cen, sram_gwen, sram_a, sram_wen, sram_d},
        {1'b0, 1'b0, 1'b0, 7'd7, 16'hF0FF, 16'hFF00});
    cyc(1, 7'd7, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("raw_gnt", rd_gnt, 1);
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("raw_data", {rd_vld, rd_data}, {1'b1, 16'h0FFF});
`endif

    // zero-mask write: accepted, no access, not buffered
    cyc(0, 7'd0, 1, 7'd7, 16'hFFFF, 16'h0000, 0);
    chk("zmask", {wr_gnt, sram_cen}, {1'b1, 1'b1});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("zmask_nobuf", wr_gnt, 1);
    cyc(1, 7'd7, 0, 7'd0, 16'h0, 16'h0, 0);
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd7_data", {rd_vld, rd_data}, {1'b1, 16'h0FFF});

    // invalidate with a buffered write pending
    cyc(1, 7'd0, 1, 7'd30, 16'h5555, 16'hFFFF, 0);
    chk("inv_cap", {rd_gnt, wr_gnt}, {1'b1, 1'b1});
    cyc(1, 7'd1, 1, 7'd31, 16'h7777, 16'hFFFF, 1);
    chk("inv_nognt", {rd_gnt, wr_gnt, sram_cen}, {1'b0, 1'b0, 1'b1});
    sweep_chk("resweep");
    cyc(1, 7'd30, 0, 7'd0, 16'h0, 16'h0, 0);
    cyc(1, 7'd5, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd30_data", {rd_vld, rd_data}, {1'b1, 16'h0000});
    cyc(0, 7'd0, 0, 7'd0, 16'h0, 16'h0, 0);
    chk("rd5_clr", {rd_vld, rd_data}, {1'b1, 16'h0000});

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
